scan_chain_driver: RTL and testbench
====================================

// Module: scan_chain_driver
// PURPOSE
//  Host-side master for the minitest serial scan harness (ports di/stb in, do out, clk).
//  Takes a parallel stimulus vector and shifts it MSB-first into the DUT's di chain.
//  Pulses stb for one cycle so the DUT loads din and captures dout.
//  Then shifts DOUT_N bits back from the DUT's do line and presents the parallel response.
//  Lets benches and on-chip sequencers drive bram/clb minitests without hand-toggling pins.
// PARAMETERS
//  DIN_N   8  DUT stimulus chain length in bits (>=1)
//  DOUT_N  8  DUT response chain length in bits (>=1)
// PORTS
//  clk        in   1       single clock, shared with DUT clk
//  rst_n      in   1       asynchronous active-low reset
//  vec_valid  in   1       stimulus offered
//  vec_ready  out  1       stimulus accepted when valid&ready
//  vec_data   in   DIN_N   stimulus vector
//  res_valid  out  1       response available
//  res_ready  in   1       response consumed when valid&ready
//  res_data   out  DOUT_N  response vector, first bit received in MSB
//  dut_di     out  1       to DUT di
//  dut_stb    out  1       to DUT stb
//  dut_do     in   1       from DUT do
//  busy       out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs are 0, state is IDLE, counters and shift registers are cleared.
//  All outputs are registered.
//  States: IDLE, SHIFT, STROBE, [WAIT], CAPTURE, HOLD.
//  IDLE
//   - vec_ready=1.
//   - On accept at edge E0: load shifter, drive dut_di=vec_data[DIN_N-1], go to SHIFT.
//  SHIFT
//   - Bit vec_data[DIN_N-1-k] is driven after edge Ek; DUT samples it at E(k+1).
//   - After DIN_N bits: dut_stb=1 for exactly one cycle (STROBE), driven after E(DIN_N), sampled at E(DIN_N+1).
//   - dut_di=0 in every state other than SHIFT.
//  CAPTURE
//   - dut_do is sampled at edges E(DIN_N+2) .. E(DIN_N+1+DOUT_N).
//   - Each sample shifts into res_data LSB, so first sample = dout[DOUT_N-1] ends in MSB.
//   - res_valid rises at E(DIN_N+1+DOUT_N): 17 edges after accept for the defaults.
//  HOLD
//   - res_valid and res_data are stable until res_ready=1.
//   - On that edge: res_valid=0, go to IDLE.
//   - vec_ready is 0 in all states except IDLE, so there is no overlap between transactions.
//  Counter width is $clog2(max(DIN_N,DOUT_N)+1); the count saturates and never wraps.
//  vec_valid during a busy state is ignored; vec_data is not sampled.
//  res_ready outside HOLD is ignored.
//  Reset mid-transaction aborts immediately with dut_stb=0; no result is produced.
//   - The DUT chain may hold a partial vector. This is harmless because every transaction
//     shifts all DIN_N bits before its strobe.
//  Exactly one dut_stb pulse per accepted vector, never more.
// CONFIGURATION
//  SCAN_DRV_DO_SYNC_EN
//   - Defined: dut_do passes through a 2-flop synchronizer. WAIT state adds 2 cycles.
//     Samples move to E(DIN_N+4) .. E(DIN_N+3+DOUT_N); res_valid rises 19 edges after accept (defaults).
//   - Undefined: dut_do is sampled directly, there is no WAIT state, and latency is as above.
// STRUCTURE
//  scan_drv_pkg:
//   - state_t enum (IDLE, SHIFT, STROBE, WAIT, CAPTURE, HOLD)
//   - SYNC_STAGES=2
//   - function cnt_w(din_n, dout_n)
//  Sub-module scan_drv_sync: 2-flop synchronizer with async active-low reset.
//   - Instantiated only under SCAN_DRV_DO_SYNC_EN.
//  Everything else (FSM, counter, tx and rx shifters) lives in scan_chain_driver.
// TESTING
//  Bench DUT model: copy of the minitest shift/strobe protocol with dout = ~din.
//  1 vec 8'hA5 -> dut_di = 1,0,1,0,0,1,0,1 at E1..E8; single dut_stb sampled at E9.
//  2 vec 8'hA5 -> res_data 8'h5A; res_valid rises 17 edges after accept;
//    vec_ready stays 0 until the res handshake completes.
//  3 res_ready held 0 for 10 cycles after res_valid -> res_valid/res_data stable;
//    no dut_stb; vec_ready 0; release gives one handshake, then IDLE.
//  4 rst_n pulsed low during SHIFT bit 4 -> dut_stb, dut_di, res_valid, busy drop asynchronously;
//    next vec 8'h3C -> res_data 8'hC3.
//  5 DIN_N=12, DOUT_N=4, vec 12'hF0F -> 12 di bits, 1 strobe, 4 samples;
//    res_data = ~din[11:8] of the model = 4'h0; latency 17.
//  6 SCAN_DRV_DO_SYNC_EN defined, repeat test 2 -> res_data 8'h5A, res_valid 19 edges after accept.

Source files
------------

// File: rtl/scan_drv_pkg.sv
// scan_drv_pkg: shared FSM state encoding, synchronizer depth and counter sizing for scan_chain_driver.
package scan_drv_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    STROBE  = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    HOLD    = 3'd5
  } state_t;
  localparam int SYNC_STAGES = 2;
  function automatic int cnt_w(input int din_n, input int dout_n);
    return $clog2((din_n > dout_n ? din_n : dout_n) + 1);
  endfunction
endpackage

// File: rtl/scan_drv_sync.sv
// scan_drv_sync: multi-flop synchronizer with async active-low reset, used on dut_do.
module scan_drv_sync
  import scan_drv_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] ff_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff_q <= '0;
    else ff_q <= {ff_q[STAGES-2:0], d_i};
  assign q_o = ff_q[STAGES-1];
endmodule

// File: rtl/scan_chain_driver.sv
// scan_chain_driver: shifts a vector MSB-first into a scan chain, pulses stb once, then captures DOUT_N response bits.
// Build option SCAN_DRV_DO_SYNC_EN routes dut_do through a 2-flop synchronizer and inserts a WAIT state.
module scan_chain_driver
  import scan_drv_pkg::*;
#(
  parameter int DIN_N  = 8,
  parameter int DOUT_N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [DIN_N-1:0]  vec_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DOUT_N-1:0] res_data,
  output logic              dut_di,
  output logic              dut_stb,
  input  logic              dut_do,
  output logic              busy
);
  localparam int CW = cnt_w(DIN_N, DOUT_N);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [DIN_N-1:0] tx_q, tx_d;
  logic [DOUT_N-1:0] rx_q, rx_d;
  logic di_q, di_d, stb_q, stb_d, rv_q, rv_d, vr_q, vr_d, busy_q, busy_d;
  logic do_s;
`ifdef SCAN_DRV_DO_SYNC_EN
  localparam state_t POST_STB = WAIT;
  scan_drv_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (dut_do),
    .q_o   (do_s)
  );
`else
  localparam state_t POST_STB = CAPTURE;
  assign do_s = dut_do;
`endif
  assign cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    di_d    = 1'b0;
    stb_d   = 1'b0;
    rv_d    = rv_q;
    case (state_q)
      IDLE: if (vec_valid && vr_q) begin
        tx_d    = vec_data << 1;
        di_d    = vec_data[DIN_N-1];
        cnt_d   = CW'(1);
        state_d = SHIFT;
      end
      SHIFT: if (cnt_q == CW'(DIN_N)) begin
        stb_d   = 1'b1;
        cnt_d   = '0;
        state_d = STROBE;
      end else begin
        di_d  = tx_q[DIN_N-1];
        tx_d  = tx_q << 1;
        cnt_d = cnt_inc;
      end
      STROBE: begin
        cnt_d   = '0;
        state_d = POST_STB;
      end
      WAIT: if (cnt_q == CW'(SYNC_STAGES-1)) begin
        cnt_d   = '0;
        state_d = CAPTURE;
      end else cnt_d = cnt_inc;
      CAPTURE: begin
        rx_d = DOUT_N'({rx_q, do_s});
        if (cnt_q == CW'(DOUT_N-1)) begin
          rv_d    = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else cnt_d = cnt_inc;
      end
      HOLD: if (res_ready) begin
        rv_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // vec_ready and busy are registered views of the upcoming state
    vr_d   = state_d == IDLE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      di_q    <= 1'b0;
      stb_q   <= 1'b0;
      rv_q    <= 1'b0;
      vr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      di_q    <= di_d;
      stb_q   <= stb_d;
      rv_q    <= rv_d;
      vr_q    <= vr_d;
      busy_q  <= busy_d;
    end
  assign vec_ready = vr_q;
  assign res_valid = rv_q;
  assign res_data  = rx_q;
  assign dut_di    = di_q;
  assign dut_stb   = stb_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_scan_chain_driver.sv
// tb_scan_chain_driver: drives an 8/8 and a 12/4 driver against minitest chain models whose dout is ~din.
module tb_scan_chain_driver;
`ifdef SCAN_DRV_DO_SYNC_EN
  localparam int SYNC_EXTRA = 2;
`else
  localparam int SYNC_EXTRA = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic vv_a = 1'b0, vv_b = 1'b0, rr_a = 1'b0, rr_b = 1'b0;
  logic [11:0] vdata = '0;
  logic vr_a, rv_a, di_a, stb_a, busy_a, do_a;
  logic vr_b, rv_b, di_b, stb_b, busy_b, do_b;
  logic [7:0] rd_a;
  logic [3:0] rd_b;
  logic [7:0] mdin_a = '0, mdout_a = '0;
  logic [11:0] mdin_b = '0;
  logic [3:0] mdout_b = '0;
  logic sel = 1'b0;
  logic m_vr, m_rv, m_di, m_stb, m_busy;
  logic [7:0] m_rd;
  int n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  scan_chain_driver #(.DIN_N(8), .DOUT_N(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .vec_valid(vv_a), .vec_ready(vr_a), .vec_data(vdata[7:0]),
    .res_valid(rv_a), .res_ready(rr_a), .res_data(rd_a),
    .dut_di(di_a), .dut_stb(stb_a), .dut_do(do_a), .busy(busy_a));
  scan_chain_driver #(.DIN_N(12), .DOUT_N(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .vec_valid(vv_b), .vec_ready(vr_b), .vec_data(vdata),
    .res_valid(rv_b), .res_ready(rr_b), .res_data(rd_b),
    .dut_di(di_b), .dut_stb(stb_b), .dut_do(do_b), .busy(busy_b));

  // Minitest chain: shift di in when stb is low, load dout=~din on stb, do = dout MSB.
  always @(posedge clk)
    if (stb_a) mdout_a <= ~mdin_a;
    else begin
      mdin_a  <= {mdin_a[6:0], di_a};
      mdout_a <= mdout_a << 1;
    end
  assign do_a = mdout_a[7];
  always @(posedge clk)
    if (stb_b) mdout_b <= ~mdin_b[11:8];
    else begin
      mdin_b  <= {mdin_b[10:0], di_b};
      mdout_b <= mdout_b << 1;
    end
  assign do_b = mdout_b[3];

  assign m_vr   = sel ? vr_b : vr_a;
  assign m_rv   = sel ? rv_b : rv_a;
  assign m_di   = sel ? di_b : di_a;
  assign m_stb  = sel ? stb_b : stb_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_rd   = sel ? {4'b0, rd_b} : rd_a;

  task automatic run_txn(input logic s, input logic [11:0] v, input int hold);
    int dn, on, lat, stbs, stb_k, exp_lat;
    logic [11:0] di_got, vm;
    logic [7:0] exp_res, held;
    logic vr_seen, busy_lost, hold_bad;
    sel = s;
    dn = s ? 12 : 8;
    on = s ? 4 : 8;
    exp_lat = dn + 1 + on + SYNC_EXTRA;
    vm = s ? v : {4'b0, v[7:0]};
    exp_res = s ? {4'b0, ~v[11:8]} : ~v[7:0];
    for (int i = 0; i < 10 && m_vr !== 1'b1; i++) @(posedge clk) #1;
    n_tot++;
    if (m_vr !== 1'b1) $display("FAIL idle_ready got %b want 1", m_vr); else n_pass++;
    vdata = v;
    if (s) vv_b = 1'b1; else vv_a = 1'b1;
    @(posedge clk) #1;
    vv_a = 1'b0; vv_b = 1'b0;
    di_got = '0; stbs = 0; stb_k = -1; lat = -1; vr_seen = 1'b0; busy_lost = 1'b0;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      if (k < dn) di_got = {di_got[10:0], m_di};
      if (m_stb) begin
        stbs++;
        if (stb_k < 0) stb_k = k;
      end
      vr_seen |= m_vr;
      busy_lost |= !m_busy;
      if (m_rv) lat = k;
      else begin
        vdata = 12'($urandom);
        if (s) vv_b = 1'($urandom); else vv_a = 1'($urandom);
        @(posedge clk) #1;
      end
    end
    vv_a = 1'b0; vv_b = 1'b0;
    n_tot++;
    if (di_got !== vm) $display("FAIL di_bits got %h want %h", di_got, vm); else n_pass++;
    n_tot++;
    if (stbs != 1) $display("FAIL stb_count got %0d want 1", stbs); else n_pass++;
    n_tot++;
    if (stb_k != dn) $display("FAIL stb_edge got %0d want %0d", stb_k, dn); else n_pass++;
    n_tot++;
    if (lat != exp_lat) $display("FAIL latency got %0d want %0d", lat, exp_lat); else n_pass++;
    n_tot++;
    if (vr_seen !== 1'b0 || busy_lost !== 1'b0)
      $display("FAIL busy_flags ready_seen %b busy_lost %b want 0 0", vr_seen, busy_lost);
    else n_pass++;
    n_tot++;
    if (m_rd !== exp_res) $display("FAIL res_data got %h want %h", m_rd, exp_res); else n_pass++;
    held = m_rd;
    hold_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk) #1;
      hold_bad |= (m_rv !== 1'b1) || (m_rd !== held) || (m_stb !== 1'b0) || (m_vr !== 1'b0);
    end
    n_tot++;
    if (hold_bad !== 1'b0) $display("FAIL hold_stable got unstable after %0d cycles want stable", hold);
    else n_pass++;
    if (s) rr_b = 1'b1; else rr_a = 1'b1;
    @(posedge clk) #1;
    rr_a = 1'b0; rr_b = 1'b0;
    n_tot++;
    if ({m_rv, m_busy, m_vr} !== 3'b001)
      $display("FAIL handshake rv/busy/ready got %b want 001", {m_rv, m_busy, m_vr});
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_tot++;
    if ({vr_a, rv_a, di_a, stb_a, busy_a, rd_a} !== '0)
      $display("FAIL reset_a got %b want 0", {vr_a, rv_a, di_a, stb_a, busy_a, rd_a});
    else n_pass++;
    n_tot++;
    if ({vr_b, rv_b, di_b, stb_b, busy_b, rd_b} !== '0)
      $display("FAIL reset_b got %b want 0", {vr_b, rv_b, di_b, stb_b, busy_b, rd_b});
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    n_tot++;
    if ({vr_a, busy_a, vr_b, busy_b} !== 4'b1010)
      $display("FAIL post_reset ready/busy got %b want 1010", {vr_a, busy_a, vr_b, busy_b});
    else n_pass++;
  endtask

  task automatic test_basic();
    run_txn(1'b0, 12'h0A5, 0);
  endtask

  task automatic test_hold();
    run_txn(1'b0, 12'h0A5, 10);
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    for (int i = 0; i < 10 && vr_a !== 1'b1; i++) @(posedge clk) #1;
    vdata = 12'h0A5;
    vv_a = 1'b1;
    @(posedge clk) #1;
    vv_a = 1'b0;
    repeat (4) @(posedge clk) #1;
    n_tot++;
    if (busy_a !== 1'b1) $display("FAIL mid_busy got %b want 1", busy_a); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_tot++;
    if ({vr_a, rv_a, di_a, stb_a, busy_a} !== 5'b0)
      $display("FAIL async_abort got %b want 00000", {vr_a, rv_a, di_a, stb_a, busy_a});
    else n_pass++;
    #2 rst_n = 1'b1;
    run_txn(1'b0, 12'h03C, 0);
  endtask

  task automatic test_dims();
    run_txn(1'b1, 12'hF0F, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, 12'($urandom), int'($urandom_range(0, 3)));
      run_txn(1'b1, 12'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 12'h0FF, 0);
    run_txn(1'b0, 12'h000, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_mid_reset();
    test_dims();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
